// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and PHT port scheduler states.
// The PHT holds 2-bit saturating counters, weakly not-taken after clear.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD,
        WR
    } PhtState;

    localparam logic [1:0] PHT_INIT_VALUE = 2'b01;

endpackage

// File: rtl/pht_fb_fifo.sv
// Synchronous FIFO for queued PHT feedback updates.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module pht_fb_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pht_port_scheduler.sv
// Shares one PHT SRAM port between lookups (always win) and queued
// feedback read-modify-writes; clears the table after reset.
module pht_port_scheduler
    import mips_core_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int INDEX_BITS = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_pred_valid,
    output BranchOutcome          o_pred,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_outcome,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [INDEX_BITS-1:0] o_mem_addr,
    output logic [1:0]            o_mem_wdata,
    input  logic [1:0]            i_mem_rdata,
    output logic                  o_init_busy,
    output logic [CW-1:0]         o_fifo_count,
    output logic [15:0]           o_drop_count
);

    function automatic logic [1:0] sat_update(logic [1:0] ctr, BranchOutcome o);
        if (o == TAKEN) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    PhtState               state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [1:0]            new_val_q, new_val_d;
    logic                  pred_valid_q;
    logic                  pred_rd_q;
    logic [15:0]           drop_q;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] head_idx;
    logic [INDEX_BITS:0]   head;
    BranchOutcome          head_out;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_pc_bits;

    assign req_idx  = i_req_pc[INDEX_BITS+1:2];
    assign head_idx = head[INDEX_BITS:1];
    assign head_out = BranchOutcome'(head[0]);

    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                              i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

    pht_fb_fifo #(
        .WIDTH (INDEX_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_fb_valid),
        .pop_i   (fifo_pop),
        .data_i  ({i_fb_pc[INDEX_BITS+1:2], i_fb_outcome}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        new_val_d   = new_val_q;
        fifo_pop    = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        unique case (state_q)
            INIT: begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = init_idx_q;
                o_mem_wdata = PHT_INIT_VALUE;
                init_idx_d  = init_idx_q + 1'b1;
                if (&init_idx_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (i_req_valid) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = req_idx;
                end else if (!fifo_empty) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = head_idx;
                    state_d    = RD;
                end
            end
            RD: begin
                new_val_d = sat_update(i_mem_rdata, head_out);
                state_d   = WR;
                if (i_req_valid) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = req_idx;
                end
            end
            WR: begin
                // A lookup bumps the write; the latched value is retried
                if (i_req_valid) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = req_idx;
                end else begin
                    o_mem_en    = 1'b1;
                    o_mem_we    = 1'b1;
                    o_mem_addr  = head_idx;
                    o_mem_wdata = new_val_q;
                    fifo_pop    = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            new_val_q    <= PHT_INIT_VALUE;
            pred_valid_q <= 1'b0;
            pred_rd_q    <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            new_val_q    <= new_val_d;
            pred_valid_q <= i_req_valid;
            pred_rd_q    <= i_req_valid && (state_q != INIT);
            if (i_fb_valid && fifo_full && !fifo_pop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign o_pred_valid = pred_valid_q;
    assign o_pred       = (pred_valid_q && pred_rd_q && i_mem_rdata[1]) ? TAKEN : NOT_TAKEN;
    assign o_init_busy  = (state_q == INIT);
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_pht_port_scheduler.sv
// Scoreboard bench: stimulus pushes expected predictions and table writes,
// a negedge monitor pops and compares against the DUT and SRAM port.
module tb_pht_port_scheduler;
    import mips_core_pkg::*;

    localparam int IB = 4;
    localparam int NE = 1 << IB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_pc = '0;
    logic         pred_valid;
    BranchOutcome pred;
    logic         fb_valid = 1'b0;
    logic [31:0]  fb_pc = '0;
    BranchOutcome fb_outcome = NOT_TAKEN;
    logic         mem_en;
    logic         mem_we;
    logic [IB-1:0] mem_addr;
    logic [1:0]   mem_wdata;
    logic [1:0]   mem_rdata = 2'b00;
    logic         init_busy;
    logic [2:0]   fifo_count;
    logic [15:0]  drop_count;

    pht_port_scheduler #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (IB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (req_valid),
        .i_req_pc     (req_pc),
        .o_pred_valid (pred_valid),
        .o_pred       (pred),
        .i_fb_valid   (fb_valid),
        .i_fb_pc      (fb_pc),
        .i_fb_outcome (fb_outcome),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_init_busy  (init_busy),
        .o_fifo_count (fifo_count),
        .o_drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // External single-port SRAM, 1-cycle read latency
    logic [1:0] sram [NE];
    initial for (int i = 0; i < NE; i++) sram[i] = 2'b11;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else mem_rdata <= sram[mem_addr];
        end
    end

    // Reference model: eventual table contents and pending indices
    int           tab [NE];
    bit           pending [NE];
    BranchOutcome exp_pred_q [$];
    logic [5:0]   exp_wr_q [$];
    int           init_exp = 0;
    int           n_pass = 0;
    int           n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mkpc(input int idx);
        logic [31:0] pc;
        pc = $urandom;
        pc[IB+1:2] = idx[IB-1:0];
        return pc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            tab[i] = 1;
            pending[i] = 1'b0;
        end
        exp_wr_q.delete();
        init_exp = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        fb_valid  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input bit in_init);
        int idx;
        idx = int'(pc[IB+1:2]);
        req_valid = 1'b1;
        req_pc    = pc;
        if (in_init || tab[idx] < 2) exp_pred_q.push_back(NOT_TAKEN);
        else exp_pred_q.push_back(TAKEN);
    endtask

    task automatic feedback(input logic [31:0] pc, input BranchOutcome o, input bit accept);
        int idx;
        idx = int'(pc[IB+1:2]);
        fb_valid   = 1'b1;
        fb_pc      = pc;
        fb_outcome = o;
        if (accept) begin
            if (o == TAKEN) tab[idx] = (tab[idx] >= 3) ? 3 : tab[idx] + 1;
            else tab[idx] = (tab[idx] <= 0) ? 0 : tab[idx] - 1;
            exp_wr_q.push_back({idx[IB-1:0], 2'(tab[idx])});
            pending[idx] = 1'b1;
        end
    endtask

    task automatic rand_lookup();
        int idx;
        if ($urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, NE - 1);
            if (!pending[idx]) lookup(mkpc(idx), 1'b0);
        end
    endtask

    task automatic drain(input bit with_lookups);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 300) begin
            if (with_lookups) rand_lookup();
            @(negedge clk);
            if (fifo_count == 0) done = 1'b1;
            cnt++;
            tick();
        end
        check("drain_done", 32'(done), 32'd1);
        for (int i = 0; i < NE; i++) pending[i] = 1'b0;
    endtask

    task automatic init_wait(input bit do_lookup);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (init_busy && cnt < 100) begin
            cnt++;
            if (do_lookup && cnt == 3) lookup($urandom, 1'b1);
            else req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("init_cycles", 32'(cnt), 32'd16);
        tick();
    endtask

    // Monitor: predictions, table writes and lookup port usage
    always @(negedge clk) begin
        if (!rst) begin
            if (pred_valid) begin
                if (exp_pred_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pred_unexpected: got valid %0d expected none", pred);
                end else begin
                    check("pred", 32'(pred), 32'(exp_pred_q.pop_front()));
                end
            end
            if (mem_en && mem_we) begin
                if (init_busy) begin
                    check("init_wr", {mem_addr, mem_wdata}, {init_exp[IB-1:0], PHT_INIT_VALUE});
                    init_exp++;
                end else if (exp_wr_q.size() == 0) begin
                    n_total++;
                    $display("FAIL upd_unexpected: got write %0h<=%0h expected none", mem_addr, mem_wdata);
                end else begin
                    check("upd_wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
                end
            end
            if (req_valid && !init_busy)
                check("lookup_port", {mem_en, mem_we, mem_addr}, {2'b10, req_pc[IB+1:2]});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_pred_valid", 32'(pred_valid), 32'd0);
        check("rst_pred", 32'(pred), 32'(NOT_TAKEN));
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;
        init_wait(1'b1);

        // Basic update: TAKEN on pc 0x40 (index 0)
        feedback(32'h40, TAKEN, 1'b1);
        tick();
        @(negedge clk);
        check("basic_rd", {mem_en, mem_we, mem_addr}, {2'b10, 4'd0});
        check("basic_fifo_count", 32'(fifo_count), 32'd1);
        tick();
        tick();
        @(negedge clk);
        check("basic_wr", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 4'd0, 2'b10});
        tick();
        tick();
        lookup(32'h40, 1'b0);
        tick();
        tick();
        for (int i = 0; i < NE; i++) pending[i] = 1'b0;

        // Saturation: 4 TAKEN then 5 NOT_TAKEN on index 7
        for (int k = 0; k < 4; k++) begin
            feedback(32'h1C, TAKEN, 1'b1);
            tick();
        end
        drain(1'b0);
        for (int k = 0; k < 5; k++) begin
            feedback(32'h1C, NOT_TAKEN, 1'b1);
            tick();
        end
        drain(1'b0);

        // Lookup priority: hold lookups through WR for 5 cycles
        feedback(32'h24, TAKEN, 1'b1);
        tick();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            lookup(32'h08, 1'b0);
            @(negedge clk);
            check("prio_no_write", 32'(mem_we), 32'd0);
            tick();
        end
        @(negedge clk);
        check("prio_write", {mem_en, mem_we, mem_addr}, {2'b11, 4'd9});
        tick();
        drain(1'b0);

        // Overflow under continuous lookups, then push+pop while full
        for (int k = 0; k < 6; k++) begin
            lookup(32'h08, 1'b0);
            feedback(32'h30, TAKEN, k < 4);
            tick();
        end
        lookup(32'h08, 1'b0);
        @(negedge clk);
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_drop_count", 32'(drop_count), 32'd2);
        tick();
        tick();
        tick();
        feedback(32'h30, NOT_TAKEN, 1'b1);
        tick();
        @(negedge clk);
        check("full_pushpop_count", 32'(fifo_count), 32'd4);
        check("full_pushpop_drop", 32'(drop_count), 32'd2);
        tick();
        drain(1'b0);

        // Randomized bursts with interleaved lookups
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                feedback(mkpc($urandom_range(0, NE - 1)),
                         BranchOutcome'($urandom_range(0, 1)), 1'b1);
                rand_lookup();
                tick();
            end
            drain(1'b1);
        end

        // Reset while the first of three updates sits in RD
        feedback(32'h14, TAKEN, 1'b0);
        tick();
        feedback(32'h18, TAKEN, 1'b0);
        tick();
        feedback(32'h20, NOT_TAKEN, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mid_rst_init_busy", 32'(init_busy), 32'd1);
        check("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        init_wait(1'b0);

        for (int r = 0; r < 5; r++) begin
            feedback(mkpc($urandom_range(0, NE - 1)),
                     BranchOutcome'($urandom_range(0, 1)), 1'b1);
            rand_lookup();
            tick();
            drain(1'b1);
        end
        tick();
        tick();
        check("pred_q_empty", 32'(exp_pred_q.size()), 32'd0);
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pht_port_scheduler.md
# pht_port_scheduler

Sequences a single-ported, externally instantiated pattern history table (PHT) of 2-bit saturating counters. It shares the one port between decode-stage prediction lookups and execute-stage feedback updates, and clears the table after reset. Lookups always win the port. Feedback is queued in a small FIFO and retired by a read-modify-write state machine in idle port cycles. It sits between the branch request/feedback interfaces and the PHT SRAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_BITS, 8, PHT index width; the table has 2^INDEX_BITS entries.
- FIFO_DEPTH, 4, feedback queue entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  decode lookup request.
- i_req_pc  in  ADDR_WIDTH  branch PC of the lookup.
- o_pred_valid  out  1  prediction valid; the cycle after a lookup.
- o_pred  out  BranchOutcome  prediction; meaningful only when o_pred_valid.
- i_fb_valid  in  1  execute feedback valid.
- i_fb_pc  in  ADDR_WIDTH  branch PC of the feedback.
- i_fb_outcome  in  BranchOutcome  resolved outcome.
- o_mem_en  out  1  SRAM port enable.
- o_mem_we  out  1  SRAM write enable.
- o_mem_addr  out  INDEX_BITS  SRAM index.
- o_mem_wdata  out  2  SRAM write data.
- i_mem_rdata  in  2  SRAM read data; 1-cycle latency.
- o_init_busy  out  1  table clear in progress.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  queued updates.
- o_drop_count  out  16  feedback events dropped because the FIFO was full; saturates at 16'hFFFF.

## Operation
- Index mapping: index = pc[INDEX_BITS+1:2], for both lookups and feedback.
- Lookups:
  - When i_req_valid is high, drive a read of the lookup index (en=1, we=0) in that cycle, in every state except INIT.
  - Next cycle: o_pred_valid=1, o_pred = TAKEN if i_mem_rdata[1] else NOT_TAKEN.
  - During INIT a lookup does not use the port; next cycle o_pred_valid=1 with o_pred=NOT_TAKEN.
- Feedback:
  - i_fb_valid pushes {index, outcome} into the FIFO, in any state including INIT.
  - If the FIFO is full and no pop happens that cycle, the event is dropped and o_drop_count increments.
  - A push and a pop in the same cycle are always accepted, even when full.
- FSM states: INIT, IDLE, RD, WR.
  - INIT:
    - Each cycle write PHT_INIT_VALUE (2'b01) to init_idx, then increment init_idx.
    - After writing index 2^INDEX_BITS-1, go to IDLE.
    - o_init_busy=1 throughout INIT.
  - IDLE: if the FIFO is non-empty and i_req_valid=0, read the head index and go to RD. Otherwise stay.
  - RD:
    - i_mem_rdata holds the head's counter; latch it.
    - Compute the new value: increment if TAKEN, decrement if NOT_TAKEN, saturating at 0 and 3.
    - Go to WR. A lookup may use the port in this cycle.
  - WR:
    - If i_req_valid=0: write the new value to the head index, pop the FIFO, go to IDLE.
    - Otherwise: hold in WR with the latched value and retry next cycle.
- Updates retire strictly in FIFO order, one at a time. Repeated updates to the same index therefore compose correctly.
- A lookup of an index with a queued or in-flight update returns the stale table value. This is permitted.
- Reset mid-operation:
  - Any in-flight update is abandoned and the FIFO is flushed.
  - init_idx=0, state=INIT, o_drop_count=0.

## Timing
- Reset values: o_pred_valid=0, o_pred=NOT_TAKEN, o_init_busy=1, o_fifo_count=0, o_drop_count=0. The o_mem_* outputs are combinational from state.
- Init duration: exactly 2^INDEX_BITS cycles after rst deasserts.
- Lookup latency: 1 cycle, unconditional; lookups are never stalled.
- Minimum update retire: 3 cycles (IDLE read, RD, WR write). Each cycle with i_req_valid=1 in IDLE or WR adds one cycle.
- Starvation: continuous lookups starve updates indefinitely. The FIFO then fills and drops are counted.
- o_fifo_count reflects the registered FIFO occupancy. A push is visible the next cycle.

## Structure
- mips_core_pkg additions: PhtState enum {INIT, IDLE, RD, WR}, PHT_INIT_VALUE = 2'b01. BranchOutcome is reused from the existing package.
- Sub-module pht_fb_fifo: a synchronous FIFO parameterized by width and depth, with push, pop, full, empty and count.
- The saturating increment/decrement is a function inside pht_port_scheduler.

## Test plan
- Init sweep: INDEX_BITS=4, deassert rst → 16 writes of 2'b01 to indices 0..15 in consecutive cycles; o_init_busy falls on cycle 16; a lookup during init returns NOT_TAKEN one cycle later.
- Basic update: after init, feedback TAKEN on pc 0x40 with no lookups → read idx 0 at t+1, write 2'b10 at t+3; a lookup of pc 0x40 at t+5 returns TAKEN at t+6.
- Saturation: four TAKEN, then five NOT_TAKEN on the same pc → written sequence 2,3,3,3 then 2,1,0,0,0.
- Lookup priority: i_req_valid held high for 5 cycles while the FSM is in WR → no write occurs; the write issues in the first cycle with i_req_valid low; every lookup still gets o_pred_valid the next cycle.
- Overflow: FIFO_DEPTH=4, continuous lookups, 6 feedback events → o_fifo_count=4, o_drop_count=2; a push with a simultaneous pop while full is accepted with no drop.
- Reset mid-update: assert rst while in RD with 3 queued updates → next cycle state INIT, o_fifo_count=0, o_drop_count=0, and no write to the update index occurs.
